// File: rtl/mac_seq_ctrl.sv
// MAC sequencer: walks the weight/data banks through the shared register-file
// read port, accumulates 8 products, then rounds/saturates to a Q3.16 result.
module mac_seq_ctrl #(
  parameter int DW    = 19,
  parameter int AW    = 3,
  parameter int DEPTH = 8,
  parameter int FRAC  = 16,
  parameter int ACCW  = 2*DW+AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          aluop_st,
  input  logic          round_en,
  input  logic          host_rd_req,
  input  logic [AW-1:0] host_rd_addr,
  output logic          host_rd_gnt,
  output logic          rf_rd_en,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] w_rdata,
  input  logic [DW-1:0] x_rdata,
  output logic          busy,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic          sat
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, ROUND, DONE} state_t;

  localparam int QW = ACCW - FRAC + 1;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt;
  logic [ACCW-1:0] acc;
  logic            start_pend;
  logic            rnd_l;
  logic            start_req, start_go;
  logic [1:0]      vld_pipe;
  logic [2*DW-1:0] prod;
  logic [ACCW:0]   rinc;
  logic [QW-1:0]   q;
  logic            ovf;

  assign start_req = aluop_st | start_pend;
  assign start_go  = (state == IDLE) & start_req & ~host_rd_req;

  // Read issue -> data one cycle later; the delayed bit gates the accumulate.
  assign vld_pipe[0] = (state == RUN);
  assign prod        = w_rdata * x_rdata;

  // Adding half an LSB before the shift gives round-half-up; the carry out of
  // the kept field lands in the overflow bits checked below.
  assign rinc = rnd_l ? ((ACCW+1)'(1) << (FRAC-1)) : '0;
  assign q    = QW'(({1'b0, acc} + rinc) >> FRAC);
  assign ovf  = |q[QW-1:DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      start_pend  <= 1'b0;
      rnd_l       <= 1'b0;
      vld_pipe[1] <= 1'b0;
      result      <= '0;
      sat         <= 1'b0;
    end else begin
      state       <= state_nxt;
      vld_pipe[1] <= vld_pipe[0];
      if (start_go) begin
        cnt        <= '0;
        acc        <= '0;
        rnd_l      <= round_en;
        start_pend <= 1'b0;
      end else if (state == IDLE && start_req) begin
        start_pend <= 1'b1;
      end
      if (state == RUN)
        cnt <= cnt + 1'b1;
      if (vld_pipe[1])
        acc <= acc + ACCW'(prod);
      if (state == ROUND) begin
        result <= ovf ? '1 : q[DW-1:0];
        sat    <= ovf;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b1;
    result_valid = 1'b0;
    host_rd_gnt  = 1'b0;
    rf_rd_en     = 1'b0;
    rf_addr      = cnt;
    case (state)
      IDLE: begin
        busy        = 1'b0;
        host_rd_gnt = host_rd_req;
        rf_rd_en    = host_rd_req;
        rf_addr     = host_rd_addr;
        if (start_go) state_nxt = RUN;
      end
      RUN: begin
        rf_rd_en = 1'b1;
        if (cnt == AW'(DEPTH-1)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE: begin
        result_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized + directed bench for mac_seq_ctrl against a cycle-count model
// that computes each result directly from the bank contents.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aluop_st = 1'b0, round_en = 1'b0, host_rd_req = 1'b0;
  logic [2:0]  host_rd_addr = '0;
  logic        host_rd_gnt, rf_rd_en, busy, result_valid, sat;
  logic [2:0]  rf_addr;
  logic [18:0] w_rdata = '0, x_rdata = '0, result;

  logic [18:0] w_mem [8];
  logic [18:0] x_mem [8];

  int total = 0, bad = 0, cyc_n = 0;
  int rv_cnt = 0, rv_cyc = -1;

  // model: k = cycles since acceptance (0 = idle)
  int          k = 0;
  bit          pend = 0, rl = 0, m_sat = 0, nxt_sat = 0;
  logic [18:0] m_res = '0, nxt_res = '0;

  always #5 clk = ~clk;

  mac_seq_ctrl dut (
    .clk(clk), .rst(rst), .aluop_st(aluop_st), .round_en(round_en),
    .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
    .host_rd_gnt(host_rd_gnt), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
    .w_rdata(w_rdata), .x_rdata(x_rdata), .busy(busy), .result(result),
    .result_valid(result_valid), .sat(sat)
  );

  // register file: data valid the cycle after the read enable, junk otherwise
  always @(posedge clk) begin
    if (rf_rd_en) begin
      w_rdata <= w_mem[rf_addr];
      x_rdata <= x_mem[rf_addr];
    end else begin
      w_rdata <= 19'($urandom);
      x_rdata <= 19'($urandom);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc_n, act, exp);
    end
  endtask

  function automatic void calc(input bit r, output logic [18:0] res, output bit s);
    longint sum = 0, qv;
    for (int i = 0; i < 8; i++) sum += longint'(w_mem[i]) * longint'(x_mem[i]);
    qv = sum >> 16;
    if (r && ((sum >> 15) & 1) == 1) qv++;
    if (qv > 64'h7FFFF) begin res = 19'h7FFFF; s = 1; end
    else begin res = 19'(qv); s = 0; end
  endfunction

  task automatic model_reset();
    k = 0; pend = 0; m_res = '0; m_sat = 0;
  endtask

  task automatic model_update();
    if (rst) model_reset();
    else if (k == 0) begin
      if (aluop_st || pend) begin
        if (host_rd_req) pend = 1;
        else begin
          pend = 0; k = 1; rl = round_en;
          calc(rl, nxt_res, nxt_sat);
        end
      end
    end else begin
      if (k == 10) begin m_res = nxt_res; m_sat = nxt_sat; end
      k = (k == 11) ? 0 : k + 1;
    end
  endtask

  task automatic compare();
    chk("busy", busy, k != 0);
    chk("result_valid", result_valid, k == 11);
    chk("host_rd_gnt", host_rd_gnt, (k == 0) && host_rd_req);
    chk("rf_rd_en", rf_rd_en, (k == 0) ? host_rd_req : (k >= 1 && k <= 8));
    if (k == 0) chk("rf_addr_idle", rf_addr, host_rd_addr);
    else if (k <= 8) chk("rf_addr_run", rf_addr, k - 1);
    chk("result", result, m_res);
    chk("sat", sat, m_sat);
    if (result_valid) begin rv_cnt++; rv_cyc = cyc_n; end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    cyc_n++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic fill(input logic [18:0] w, input logic [18:0] x);
    for (int i = 0; i < 8; i++) begin w_mem[i] = w; x_mem[i] = x; end
  endtask

  task automatic run_seq(input bit rnd, input bit conflict, input bit toggle,
                         input bit restart, input int rst_at,
                         output int lat, output int rvc);
    int s;
    rv_cnt = 0; rv_cyc = -1;
    round_en = rnd; aluop_st = 1;
    if (conflict) begin host_rd_req = 1; host_rd_addr = 3'd5; end
    s = cyc_n;
    #1;
    if (conflict) begin
      chk("arb_gnt_c0", host_rd_gnt, 1);
      chk("arb_addr_c0", rf_addr, 5);
    end
    for (int c = 1; c <= 30; c++) begin
      tick();
      aluop_st = restart && (c == 4);
      if (toggle && c == 3) round_en = !rnd;
      if (conflict && c == 1) host_rd_req = 0;
      if (conflict && c == 3) host_rd_req = 1;
      if (rst_at != 0 && c == rst_at + 1) rst = 0;
      #1;
      if (conflict && c == 12) chk("arb_gnt_done", host_rd_gnt, 0);
      if (conflict && c == 13) begin
        chk("arb_gnt_after", host_rd_gnt, 1);
        host_rd_req = 0;
      end
      if (rst_at != 0 && c == rst_at) begin
        rst = 1; model_reset(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_sat", sat, 0);
      end
    end
    lat = (rv_cyc < 0) ? -1 : rv_cyc - s;
    rvc = rv_cnt;
  endtask

  initial begin
    int lat, rvc;
    fill('0, '0);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 0);
    chk("reset_rv", result_valid, 0);
    chk("reset_sat", sat, 0);
    chk("reset_rden", rf_rd_en, 0);
    chk("reset_gnt", host_rd_gnt, 0);
    tick(); tick();
    rst = 0;
    tick();

    // basic: 8 * 0.5 * 1.0 = 4.0
    fill(19'h08000, 19'h10000);
    run_seq(1, 0, 0, 0, 0, lat, rvc);
    chk("s1_lat", lat, 11); chk("s1_rvc", rvc, 1);
    chk("s1_res", result, 19'h40000); chk("s1_sat", sat, 0);

    // saturation: 8 * 1.0 = 8.0
    fill(19'h10000, 19'h10000);
    run_seq(0, 0, 0, 0, 0, lat, rvc);
    chk("s2_res", result, 19'h7FFFF); chk("s2_sat", sat, 1);

    // rounding: single product of exactly half an LSB
    fill('0, '0);
    w_mem[0] = 19'h00001; x_mem[0] = 19'h08000;
    run_seq(1, 0, 0, 0, 0, lat, rvc);
    chk("s3_rnd", result, 19'h00001); chk("s3_rnd_sat", sat, 0);
    run_seq(0, 0, 0, 0, 0, lat, rvc);
    chk("s3_trunc", result, 19'h00000);
    run_seq(1, 0, 1, 0, 0, lat, rvc);
    chk("s3_toggle", result, 19'h00001);

    // arbitration: host wins the start cycle
    fill(19'h08000, 19'h10000);
    run_seq(1, 1, 0, 0, 0, lat, rvc);
    chk("s4_lat", lat, 12); chk("s4_res", result, 19'h40000);

    // reset mid-run, then a clean rerun
    run_seq(1, 0, 0, 0, 5, lat, rvc);
    chk("s5_rvc", rvc, 0); chk("s5_res_hold", result, 0);
    run_seq(1, 0, 0, 0, 0, lat, rvc);
    chk("s5_rerun_lat", lat, 11); chk("s5_rerun_res", result, 19'h40000);

    // start while busy is ignored
    run_seq(1, 0, 0, 1, 0, lat, rvc);
    chk("s6_lat", lat, 11); chk("s6_rvc", rvc, 1);

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if (k == 0 && $urandom_range(0, 5) == 0) begin
        logic [18:0] m;
        case ($urandom_range(0, 4))
          0: m = 19'h7FFFF;
          1: m = 19'h1FFFF;
          2: m = 19'h0FFFF;
          3: m = 19'h03FFF;
          default: m = 19'h001FF;
        endcase
        for (int i = 0; i < 8; i++) begin
          w_mem[i] = 19'($urandom) & m;
          x_mem[i] = 19'($urandom) & m;
        end
      end
      aluop_st     = ($urandom_range(0, 9) == 0);
      host_rd_req  = ($urandom_range(0, 2) == 0);
      host_rd_addr = 3'($urandom);
      round_en     = 1'($urandom);
      tick();
    end
    aluop_st = 0; host_rd_req = 0;
    for (int n = 0; n < 15; n++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer and arbiter for the MAC datapath behind the SPI slave. On an ALU-start pulse it walks the 8-entry weight bank and 8-entry MAC-data bank through the shared register-file read port, multiply-accumulates all pairs, then rounds or truncates and saturates the sum to a 19-bit result. When it is idle, it grants the same read port to the SPI read path.

Parameters:
DW, 19, register data width (Q3.16 unsigned fixed point)
AW, 3, register address width
DEPTH, 8, entries per bank (= 2**AW)
FRAC, 16, fractional bits of DW
ACCW, 2*DW+AW (41), accumulator width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
aluop_st  in  1  start pulse (sampled level)
round_en  in  1  1 = round half up, 0 = truncate; latched at start acceptance
host_rd_req  in  1  SPI read-path request for the read port
host_rd_addr  in  AW  SPI read address
host_rd_gnt  out  1  read port granted to host this cycle
rf_rd_en  out  1  register-file read enable
rf_addr  out  AW  register-file read address (both banks)
w_rdata  in  DW  weight-bank data, valid the cycle after rf_rd_en
x_rdata  in  DW  data-bank data, valid the cycle after rf_rd_en
busy  out  1  sequence in progress
result  out  DW  last MAC result, held until the next result
result_valid  out  1  one-cycle pulse when result updates
sat  out  1  last result saturated; updates with result

Behaviour:
- Reset values: busy=0, result=0, result_valid=0, sat=0, rf_rd_en=0, rf_addr=0, host_rd_gnt=0. Internal state: cnt=0, acc=0, start_pend=0, state=IDLE.
- States: IDLE, RUN, DRAIN, ROUND, DONE.
- IDLE:
  - rf_rd_en=host_rd_req; rf_addr=host_rd_addr; host_rd_gnt=host_rd_req. These are combinational.
  - Start taken (aluop_st or start_pend) with host_rd_req=0: go to RUN, cnt=0, acc=0, latch round_en, clear start_pend.
  - Start taken with host_rd_req=1: the host wins that cycle, start_pend is set, and the sequence begins on the next cycle where host_rd_req=0.
- RUN:
  - rf_rd_en=1, rf_addr=cnt, cnt increments each cycle; 8 cycles for addresses 0..7. The transition at cnt=7 goes to DRAIN.
  - Starting the cycle after each issue, acc += w_rdata*x_rdata. The product is unsigned DW×DW → 2*DW bits, zero-extended to ACCW.
- DRAIN: one cycle; rf_rd_en=0; performs the final (8th) accumulate.
- ROUND: one cycle.
  - t = acc[FRAC+DW-1:FRAC] + (round_en_latched & acc[FRAC-1]).
  - If acc[ACCW-1:FRAC+DW] != 0 or t overflows DW bits: result=all ones (19'h7FFFF), sat=1.
  - Otherwise result=t, sat=0.
  - Result is registered at the end of the cycle.
- DONE: one cycle; result_valid=1; go to IDLE.
- busy=1 in RUN, DRAIN, ROUND and DONE.
- Latency: start sampled in cycle 0 (IDLE, no host conflict) → addresses issued in cycles 1–8 → result_valid=1 in cycle 11. With a host conflict the whole sequence shifts by the number of cycles start was deferred.
- Start while busy (RUN..DONE): ignored; start_pend is not set.
- host_rd_req while busy: host_rd_gnt=0. The host must hold req; the grant arrives in the first IDLE cycle.
- A host read is one cycle: rdata is valid the cycle after grant, passed through by the read path (not by this block).
- Reset mid-operation: immediately returns to IDLE and clears result and sat; no result_valid is produced.
- No arithmetic wrap: the accumulator width covers the full 8-term sum.

Test Plan:
1. Basic MAC: w[i]=0x08000 (0.5), x[i]=0x10000 (1.0) for i=0..7; pulse aluop_st → rf_addr 0..7 in cycles 1–8; result=0x40000 (4.0), sat=0, result_valid in cycle 11 only.
2. Saturation: w[i]=x[i]=0x10000 → sum 8.0 → result=0x7FFFF, sat=1.
3. Rounding: w[0]=0x00001, x[0]=0x08000, all other entries 0.
   - round_en=1 → result=0x00001.
   - Repeat with round_en=0 → result=0x00000.
   - Toggle round_en mid-run → no effect on the result.
4. Arbitration: host_rd_req=1 with host_rd_addr=5 in the same IDLE cycle as aluop_st.
   - host_rd_gnt=1 and rf_addr=5 that cycle; the sequence starts the next cycle.
   - result_valid arrives one cycle later than in scenario 1.
   - host_rd_req held during busy → gnt=0 until the cycle after result_valid.
5. Reset mid-run: assert rst in cycle 5 of scenario 1 → busy=0, result=0, sat=0 asynchronously, no result_valid. A new start after reset produces a correct 0x40000.
6. Start during busy: second aluop_st in cycle 4 → ignored; exactly one result_valid in cycle 11; no second run follows.
